// File: rtl/dgst_out_buf_if.sv
// Digest word stream: 32-bit MSB-aligned words with byte count, last marker and completion pulse.
// Master (digest buffer) drives data/valid/size/last/done; slave (SPI/host path) drives snd_rdy.
interface dgst_out_buf_if;
    logic [31:0] snd_d;
    logic        snd_vld;
    logic        snd_rdy;
    logic [1:0]  snd_size;
    logic        snd_last;
    logic        snd_done;

    modport master (
        output snd_d,
        output snd_vld,
        input  snd_rdy,
        output snd_size,
        output snd_last,
        output snd_done
    );

    modport slave (
        input  snd_d,
        input  snd_vld,
        output snd_rdy,
        input  snd_size,
        input  snd_last,
        input  snd_done
    );
endinterface

// File: rtl/dgst_out_buf.sv
// Captures a SHA-256/384 digest in one cycle and streams it MSB-first as 32-bit words.
// Latency: first word valid the cycle after o_buf_en; one word per cycle while snd_rdy is high.
// Backpressure: outputs are registered and hold stable while snd_vld & !snd_rdy.
module dgst_out_buf #(
    parameter int DGST_W = 512,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s1_flg_384,
    input  logic              o_buf_en,
    input  logic              o_buf_clr,
    output logic              o_buf_rdy,
    input  logic [LEN_W-1:0]  out_len,
    input  logic [DGST_W-1:0] hash_f,
    dgst_out_buf_if.master    snd
);

    localparam logic [1:0] ST_IDLE = 2'b01;
    localparam logic [1:0] ST_SEND = 2'b10;

    logic [1:0]        state_q;
    logic [DGST_W-1:0] dgst_q;
    logic [3:0]        cnt_q;
    logic [3:0]        last_idx_q;
    logic [1:0]        ls_q;

    logic [31:0]       snd_d_q;
    logic              snd_vld_q;
    logic [1:0]        snd_size_q;
    logic              snd_last_q;
    logic              snd_done_q;

    // Load-time length decode: clamp to the digest size, 0 means the full digest.
    logic [6:0] max_len;
    logic [6:0] len_ext;
    logic [6:0] n_len;
    logic [3:0] load_last_idx;
    logic [1:0] load_ls;

    always_comb begin
        max_len       = s1_flg_384 ? 7'd48 : 7'd32;
        len_ext       = 7'(out_len);
        n_len         = ((len_ext == 7'd0) || (len_ext > max_len)) ? max_len : len_ext;
        load_last_idx = 4'((n_len - 7'd1) >> 2);
        load_ls       = n_len[1:0];
    end

    function automatic logic [31:0] word_at(input logic [DGST_W-1:0] d, input logic [3:0] k);
        return d[DGST_W - 1 - 32 * int'(k) -: 32];
    endfunction

    // Next word to present: word 0 of the incoming digest on load, else the following stored word.
    logic              is_idle;
    logic [DGST_W-1:0] sel_dgst;
    logic [3:0]        sel_idx;
    logic [3:0]        sel_last_idx;
    logic [1:0]        sel_ls;
    logic [31:0]       nxt_d;
    logic [1:0]        nxt_size;
    logic              nxt_last;

    always_comb begin
        is_idle      = state_q[0];
        sel_dgst     = is_idle ? hash_f        : dgst_q;
        sel_idx      = is_idle ? 4'd0          : 4'(cnt_q + 4'd1);
        sel_last_idx = is_idle ? load_last_idx : last_idx_q;
        sel_ls       = is_idle ? load_ls       : ls_q;
        nxt_last     = (sel_idx == sel_last_idx);
        nxt_size     = nxt_last ? sel_ls : 2'b00;
        nxt_d        = word_at(sel_dgst, sel_idx);
        if (nxt_last && (sel_ls != 2'b00)) begin
            nxt_d = nxt_d & ~(32'hFFFF_FFFF >> {sel_ls, 3'b000});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dgst_q     <= '0;
            cnt_q      <= 4'd0;
            last_idx_q <= 4'd0;
            ls_q       <= 2'b00;
            snd_d_q    <= 32'd0;
            snd_vld_q  <= 1'b0;
            snd_size_q <= 2'b00;
            snd_last_q <= 1'b0;
            snd_done_q <= 1'b0;
        end else if (o_buf_clr) begin
            state_q    <= ST_IDLE;
            dgst_q     <= '0;
            cnt_q      <= 4'd0;
            last_idx_q <= 4'd0;
            ls_q       <= 2'b00;
            snd_d_q    <= 32'd0;
            snd_vld_q  <= 1'b0;
            snd_size_q <= 2'b00;
            snd_last_q <= 1'b0;
            snd_done_q <= 1'b0;
        end else begin
            snd_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (o_buf_en) begin
                        state_q    <= ST_SEND;
                        dgst_q     <= hash_f;
                        cnt_q      <= 4'd0;
                        last_idx_q <= load_last_idx;
                        ls_q       <= load_ls;
                        snd_vld_q  <= 1'b1;
                        snd_d_q    <= nxt_d;
                        snd_size_q <= nxt_size;
                        snd_last_q <= nxt_last;
                    end
                end
                ST_SEND: begin
                    if (snd_vld_q && snd.snd_rdy) begin
                        if (cnt_q == last_idx_q) begin
                            state_q    <= ST_IDLE;
                            snd_vld_q  <= 1'b0;
                            snd_d_q    <= 32'd0;
                            snd_size_q <= 2'b00;
                            snd_last_q <= 1'b0;
                            snd_done_q <= 1'b1;
                        end else begin
                            cnt_q      <= 4'(cnt_q + 4'd1);
                            snd_d_q    <= nxt_d;
                            snd_size_q <= nxt_size;
                            snd_last_q <= nxt_last;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    snd_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_buf_rdy    = state_q[0];
    assign snd.snd_d    = snd_d_q;
    assign snd.snd_vld  = snd_vld_q;
    assign snd.snd_size = snd_size_q;
    assign snd.snd_last = snd_last_q;
    assign snd.snd_done = snd_done_q;

endmodule

// File: tb/tb_dgst_out_buf.sv
// Bench for dgst_out_buf: per-scenario tasks plus a scoreboard monitor on the word stream.
module tb_dgst_out_buf;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  size;
        logic        last;
    } word_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s1_flg_384;
    logic         o_buf_en;
    logic         o_buf_clr;
    logic         o_buf_rdy;
    logic [5:0]   out_len;
    logic [511:0] hash_f;

    dgst_out_buf_if sif ();

    dgst_out_buf #(.DGST_W(512), .LEN_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s1_flg_384 (s1_flg_384),
        .o_buf_en   (o_buf_en),
        .o_buf_clr  (o_buf_clr),
        .o_buf_rdy  (o_buf_rdy),
        .out_len    (out_len),
        .hash_f     (hash_f),
        .snd        (sif)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    word_t exp_q[$];
    int    done_cnt = 0;
    int    acc_cnt  = 0;
    logic [31:0] last_d;
    logic [1:0]  last_size;
    logic        hold_vld = 1'b0;
    word_t       hold_w;
    logic        acc_last_prev = 1'b0;

    // Scoreboard monitor: pops expected words on each handshake, checks stall stability and done timing.
    always @(negedge clk) begin
        word_t cur;
        word_t w;
        cur = '{d: sif.snd_d, size: sif.snd_size, last: sif.snd_last};
        if (!rst_n) begin
            hold_vld      = 1'b0;
            acc_last_prev = 1'b0;
        end else begin
            total++;
            if (sif.snd_done !== acc_last_prev) begin
                bad++;
                $display("FAIL done_pulse: got %b want %b at %0t", sif.snd_done, acc_last_prev, $time);
            end
            if (sif.snd_done === 1'b1) done_cnt++;
            if (hold_vld && sif.snd_vld) begin
                total++;
                if (cur !== hold_w) begin
                    bad++;
                    $display("FAIL stall_stable: got %h/%b/%b want %h/%b/%b", cur.d, cur.size, cur.last,
                             hold_w.d, hold_w.size, hold_w.last);
                end
            end
            acc_last_prev = 1'b0;
            if (sif.snd_vld && sif.snd_rdy) begin
                acc_cnt++;
                last_d    = cur.d;
                last_size = cur.size;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: got %h with no word expected", cur.d);
                end else begin
                    w = exp_q.pop_front();
                    if (cur !== w) begin
                        bad++;
                        $display("FAIL word: got d=%h size=%b last=%b want d=%h size=%b last=%b",
                                 cur.d, cur.size, cur.last, w.d, w.size, w.last);
                    end
                end
                acc_last_prev = cur.last;
            end
            hold_vld = sif.snd_vld && !sif.snd_rdy;
            hold_w   = cur;
        end
    end

    function automatic logic [511:0] pat_hash();
        logic [511:0] h;
        for (int k = 0; k < 16; k++) h[511 - 32*k -: 32] = {4{8'(k)}};
        return h;
    endfunction

    function automatic logic [511:0] rnd_hash();
        logic [511:0] h;
        for (int k = 0; k < 16; k++) h[511 - 32*k -: 32] = $urandom();
        return h;
    endfunction

    task automatic push_expected(input logic flg, input logic [5:0] len, input logic [511:0] h);
        int mx, n, w, r;
        word_t e;
        mx = flg ? 48 : 32;
        n  = (int'(len) == 0 || int'(len) > mx) ? mx : int'(len);
        w  = (n + 3) / 4;
        r  = n % 4;
        for (int k = 0; k < w; k++) begin
            e.d    = h[511 - 32*k -: 32];
            e.last = (k == w - 1);
            e.size = e.last ? 2'(r) : 2'b00;
            if (e.last && r != 0) e.d = e.d & (32'hFFFF_FFFF << (8 * (4 - r)));
            exp_q.push_back(e);
        end
    endtask

    // Loads a digest, then scrambles the inputs so any re-latch would corrupt the stream.
    task automatic start(input logic flg, input logic [5:0] len, input logic [511:0] h);
        @(posedge clk); #1;
        s1_flg_384 = flg;
        out_len    = len;
        hash_f     = h;
        o_buf_en   = 1'b1;
        push_expected(flg, len, h);
        @(posedge clk); #1;
        o_buf_en   = 1'b0;
        hash_f     = ~h;
        s1_flg_384 = ~flg;
        out_len    = 6'($urandom_range(1, 63));
    endtask

    task automatic wait_idle(input bit rand_rdy, input int bound, input string nm);
        bit ok = 0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !sif.snd_vld && o_buf_rdy) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            if (rand_rdy) sif.snd_rdy = 1'($urandom_range(0, 1));
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout: stream not finished after %0d cycles, %0d words pending", nm, bound, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++;
        if ({o_buf_rdy, sif.snd_vld, sif.snd_d, sif.snd_size, sif.snd_last, sif.snd_done} !== {1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b d=%h size=%b last=%b done=%b want 1 0 0 0 0 0",
                     o_buf_rdy, sif.snd_vld, sif.snd_d, sif.snd_size, sif.snd_last, sif.snd_done);
        end
    endtask

    task automatic test_full256();
        int d0, a0, got;
        d0 = done_cnt; a0 = acc_cnt; got = -1;
        sif.snd_rdy = 1'b1;
        start(1'b0, 6'd0, pat_hash());
        @(negedge clk);
        total++;
        if (sif.snd_vld !== 1'b1 || sif.snd_d !== 32'h0000_0000) begin
            bad++;
            $display("FAIL first_word256: got vld=%b d=%h want 1 00000000", sif.snd_vld, sif.snd_d);
        end
        for (int n = 2; n < 30; n++) begin
            @(negedge clk);
            if (sif.snd_done === 1'b1) begin got = n; break; end
        end
        total++;
        if (got != 9) begin
            bad++;
            $display("FAIL done_latency256: got cycle %0d want 9", got);
        end
        @(negedge clk);
        total++;
        if (last_d !== 32'h0707_0707 || last_size !== 2'b00 || acc_cnt - a0 != 8) begin
            bad++;
            $display("FAIL last_word256: got d=%h size=%b words=%0d want 07070707 00 8", last_d, last_size, acc_cnt - a0);
        end
        total++;
        if (o_buf_rdy !== 1'b1 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL idle256: got rdy=%b done=%0d want 1 1", o_buf_rdy, done_cnt - d0);
        end
    endtask

    task automatic test_full384();
        int a0;
        a0 = acc_cnt;
        sif.snd_rdy = 1'b1;
        start(1'b1, 6'd0, pat_hash());
        wait_idle(0, 40, "full384");
        total++;
        if (last_d !== 32'h0B0B_0B0B || last_size !== 2'b00 || acc_cnt - a0 != 12) begin
            bad++;
            $display("FAIL last_word384: got d=%h size=%b words=%0d want 0b0b0b0b 00 12", last_d, last_size, acc_cnt - a0);
        end
    endtask

    task automatic test_partial();
        logic [511:0] h;
        int a0;
        a0 = acc_cnt;
        h = rnd_hash();
        h[511 - 32*5 -: 32] = 32'hAABB_CCDD;
        sif.snd_rdy = 1'b1;
        start(1'b1, 6'd22, h);
        wait_idle(0, 40, "partial22");
        total++;
        if (last_d !== 32'hAABB_0000 || last_size !== 2'b10 || acc_cnt - a0 != 6) begin
            bad++;
            $display("FAIL partial22: got d=%h size=%b words=%0d want aabb0000 10 6", last_d, last_size, acc_cnt - a0);
        end
    endtask

    task automatic test_clamp_and_one();
        int a0;
        a0 = acc_cnt;
        sif.snd_rdy = 1'b1;
        start(1'b0, 6'd60, rnd_hash());
        wait_idle(0, 40, "clamp60");
        total++;
        if (acc_cnt - a0 != 8 || last_size !== 2'b00) begin
            bad++;
            $display("FAIL clamp60: got words=%0d size=%b want 8 00", acc_cnt - a0, last_size);
        end
        a0 = acc_cnt;
        start(1'b0, 6'd1, {32'hFFFF_FFFF, 480'd0});
        wait_idle(0, 40, "len1");
        total++;
        if (acc_cnt - a0 != 1 || last_size !== 2'b01 || last_d !== 32'hFF00_0000) begin
            bad++;
            $display("FAIL len1: got words=%0d size=%b d=%h want 1 01 ff000000", acc_cnt - a0, last_size, last_d);
        end
    endtask

    task automatic test_backpressure();
        int d0;
        d0 = done_cnt;
        for (int s = 0; s < 8; s++) begin
            sif.snd_rdy = 1'($urandom_range(0, 1));
            start(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), rnd_hash());
            wait_idle(1, 400, "backpressure");
        end
        total++;
        if (done_cnt - d0 != 8) begin
            bad++;
            $display("FAIL bp_done_count: got %0d want 8", done_cnt - d0);
        end
    endtask

    task automatic test_clear();
        logic [511:0] h, hn;
        int d0;
        d0 = done_cnt;
        h  = rnd_hash();
        hn = rnd_hash();
        sif.snd_rdy = 1'b0;
        start(1'b1, 6'd0, h);
        sif.snd_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sif.snd_rdy = 1'b0;
        o_buf_en    = 1'b1;
        hash_f      = hn;
        @(negedge clk);
        total++;
        if (sif.snd_vld !== 1'b1 || sif.snd_d !== h[511 - 32*3 -: 32]) begin
            bad++;
            $display("FAIL clr_word3: got vld=%b d=%h want 1 %h", sif.snd_vld, sif.snd_d, h[511 - 32*3 -: 32]);
        end
        @(posedge clk); #1;
        o_buf_en  = 1'b0;
        o_buf_clr = 1'b1;
        @(posedge clk); #1;
        o_buf_clr = 1'b0;
        @(negedge clk);
        total++;
        if ({sif.snd_vld, o_buf_rdy, sif.snd_done, sif.snd_d, sif.snd_last} !== {1'b0, 1'b1, 1'b0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL clr_outputs: got vld=%b rdy=%b done=%b d=%h last=%b want 0 1 0 0 0",
                     sif.snd_vld, o_buf_rdy, sif.snd_done, sif.snd_d, sif.snd_last);
        end
        total++;
        if (exp_q.size() != 9) begin
            bad++;
            $display("FAIL clr_pending: got %0d words outstanding want 9", exp_q.size());
        end
        exp_q.delete();
        @(posedge clk); #1;
        o_buf_en  = 1'b1;
        o_buf_clr = 1'b1;
        @(posedge clk); #1;
        o_buf_en  = 1'b0;
        o_buf_clr = 1'b0;
        @(negedge clk);
        total++;
        if (sif.snd_vld !== 1'b0 || o_buf_rdy !== 1'b1) begin
            bad++;
            $display("FAIL en_with_clr: got vld=%b rdy=%b want 0 1", sif.snd_vld, o_buf_rdy);
        end
        sif.snd_rdy = 1'b1;
        start(1'b0, 6'd0, hn);
        @(negedge clk);
        total++;
        if (sif.snd_vld !== 1'b1 || sif.snd_d !== hn[511 -: 32]) begin
            bad++;
            $display("FAIL restart_word0: got vld=%b d=%h want 1 %h", sif.snd_vld, sif.snd_d, hn[511 -: 32]);
        end
        wait_idle(0, 40, "restart");
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL clr_done_count: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_async_reset();
        sif.snd_rdy = 1'b0;
        start(1'b1, 6'd0, rnd_hash());
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({sif.snd_vld, o_buf_rdy, sif.snd_d, sif.snd_last} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got vld=%b rdy=%b d=%h last=%b want 0 1 0 0",
                     sif.snd_vld, o_buf_rdy, sif.snd_d, sif.snd_last);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sif.snd_rdy = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        s1_flg_384  = 1'b0;
        o_buf_en    = 1'b0;
        o_buf_clr   = 1'b0;
        out_len     = 6'd0;
        hash_f      = '0;
        sif.snd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_full256();
        test_full384();
        test_partial();
        test_clamp_and_one();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_full256();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
